// File: rtl/gray_arb_pkg.sv
// Shared types and gray-code helpers for the gray ticket arbiter.
// Helpers work on 32-bit values; callers cast to their own width (W <= 32).
package gray_arb_pkg;

  typedef enum logic {IDLE, HOLD} gta_state_e;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int s = 1; s < 32; s = s << 1) b = b ^ (b >> s);
    return b;
  endfunction

endpackage

// File: rtl/gray_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// searching circularly.
module gray_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [PW-1:0]   idx,
  output logic            any
);

  int          c;
  logic [PW-1:0] c_idx;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    c      = 0;
    c_idx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      c     = (int'(ptr) + i) % NREQ;
      c_idx = PW'(c);
      if (!any && req[c_idx]) begin
        any           = 1'b1;
        idx           = c_idx;
        onehot[c_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gray_ticket_arbiter.sv
// Round-robin arbiter handing out tickets from one shared gray counter,
// with an optional idle hold window after each grant.
module gray_ticket_arbiter
  import gray_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int W        = 4,
  parameter int HOLD_CYC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            clr,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [W-1:0]    ticket,
  output logic [W-1:0]    cnt_gray,
  output logic            wrap,
  output logic            busy
);

  localparam int PW = $clog2(NREQ);
  localparam int HW = 8;

  gta_state_e      state, state_nx;
  logic [W-1:0]    bin, bin_nx, cnt_gray_nx, ticket_nx;
  logic [PW-1:0]   ptr, ptr_nx, pick_idx;
  logic [NREQ-1:0] pick_onehot, gnt_nx;
  logic            pick_any, wrap_nx;
  logic [HW-1:0]   hold_cnt, hold_nx;

  gray_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    state_nx  = state;
    bin_nx    = bin;
    ticket_nx = ticket;
    ptr_nx    = ptr;
    hold_nx   = hold_cnt;
    gnt_nx    = '0;
    wrap_nx   = 1'b0;
    if (clr) begin
      bin_nx   = '0;
      state_nx = IDLE;
      hold_nx  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (en && pick_any) begin
            gnt_nx    = pick_onehot;
            ticket_nx = cnt_gray;
            bin_nx    = bin + W'(1);
            wrap_nx   = &bin;
            ptr_nx    = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
            if (HOLD_CYC > 0) begin
              state_nx = HOLD;
              hold_nx  = HW'(HOLD_CYC - 1);
            end
          end
        end
        HOLD: begin
          if (hold_cnt == '0) state_nx = IDLE;
          else                hold_nx  = hold_cnt - HW'(1);
        end
        default: state_nx = IDLE;
      endcase
    end
    // gray is formed before the flop so cnt_gray never glitches through a decode
    cnt_gray_nx = W'(bin2gray(32'(bin_nx)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bin      <= '0;
      cnt_gray <= '0;
      ticket   <= '0;
      gnt      <= '0;
      wrap     <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nx;
      bin      <= bin_nx;
      cnt_gray <= cnt_gray_nx;
      ticket   <= ticket_nx;
      gnt      <= gnt_nx;
      wrap     <= wrap_nx;
      ptr      <= ptr_nx;
      hold_cnt <= hold_nx;
    end
  end

  assign busy = (state == HOLD);

endmodule

// File: tb/tb_gray_ticket_arbiter.sv
// Bench for gray_ticket_arbiter: two instances (HOLD_CYC 0 and 2) share the
// stimulus; a ticket-level reference model feeds a scoreboard queue.
module tb_gray_ticket_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] req = 4'h0;

  logic [3:0] gnt_a   [2];
  logic [3:0] tk_a    [2];
  logic [3:0] cg_a    [2];
  logic       wrap_a  [2];
  logic       busy_a  [2];

  gray_ticket_arbiter #(.NREQ(NREQ), .W(W), .HOLD_CYC(0)) u_h0 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .req(req),
    .gnt(gnt_a[0]), .ticket(tk_a[0]), .cnt_gray(cg_a[0]),
    .wrap(wrap_a[0]), .busy(busy_a[0]));

  gray_ticket_arbiter #(.NREQ(NREQ), .W(W), .HOLD_CYC(2)) u_h2 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .req(req),
    .gnt(gnt_a[1]), .ticket(tk_a[1]), .cnt_gray(cg_a[1]),
    .wrap(wrap_a[1]), .busy(busy_a[1]));

  always #5 clk = ~clk;

  typedef struct {
    int         inst;
    int         cyc;
    logic [3:0] g;
    logic [3:0] tk;
    logic       wr;
  } exp_t;

  exp_t       sbq[$];
  int         cyc;
  int         seq  [2];
  int         ptr  [2];
  int         hold [2];
  logic [3:0] last_tk [2];
  logic       clr_seen;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       t2_on = 1'b0;
  logic [3:0] t2_log[$];

  function automatic logic [3:0] gray_of(input int v);
    return 4'(v ^ (v >> 1));
  endfunction

  function automatic int hold_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  task automatic chk(input string nm, input int d, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s inst%0d cyc%0d: got %0h want %0h", nm, d, cyc, act, exp);
    end
  endtask

  // Reference model: one step per clock edge from the sampled inputs.
  always @(posedge clk or negedge rst_n) begin
    int   k;
    int   j;
    exp_t e;
    if (!rst_n) begin
      cyc      = 0;
      clr_seen = 1'b0;
      sbq.delete();
      for (int d = 0; d < 2; d++) begin
        seq[d] = 0; ptr[d] = 0; hold[d] = 0; last_tk[d] = 4'h0;
      end
    end else begin
      cyc++;
      clr_seen = clr;
      for (int d = 0; d < 2; d++) begin
        if (clr) begin
          seq[d]  = 0;
          hold[d] = 0;
        end else if (hold[d] > 0) begin
          hold[d]--;
        end else if (en && req != 4'h0) begin
          k = -1;
          for (int i = 0; i < NREQ; i++) begin
            j = (ptr[d] + i) % NREQ;
            if (k < 0 && req[j[1:0]]) k = j;
          end
          e.inst = d;
          e.cyc  = cyc;
          e.g    = 4'(1 << k);
          e.tk   = gray_of(seq[d]);
          e.wr   = (seq[d] == 15);
          sbq.push_back(e);
          last_tk[d] = e.tk;
          seq[d]  = (seq[d] + 1) % 16;
          ptr[d]  = (k + 1) % NREQ;
          hold[d] = hold_of(d);
        end
      end
    end
  end

  // Monitor: compares DUT outputs against the scoreboard and model state.
  logic [3:0] prev_cg [2];
  always @(negedge clk or negedge rst_n) begin
    exp_t e;
    bit   seen [2];
    if (!rst_n) begin
      prev_cg[0] = 4'h0;
      prev_cg[1] = 4'h0;
    end else begin
      seen[0] = 1'b0;
      seen[1] = 1'b0;
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front();
        seen[e.inst] = 1'b1;
        chk("gnt", e.inst, int'(gnt_a[e.inst]), int'(e.g));
        chk("ticket", e.inst, int'(tk_a[e.inst]), int'(e.tk));
        chk("wrap_on_gnt", e.inst, int'(wrap_a[e.inst]), int'(e.wr));
      end
      for (int d = 0; d < 2; d++) begin
        if (!seen[d]) begin
          chk("gnt_idle", d, int'(gnt_a[d]), 0);
          chk("wrap_idle", d, int'(wrap_a[d]), 0);
          chk("ticket_hold", d, int'(tk_a[d]), int'(last_tk[d]));
        end
        chk("cnt_gray", d, int'(cg_a[d]), int'(gray_of(seq[d])));
        chk("busy", d, int'(busy_a[d]), (hold[d] > 0) ? 1 : 0);
        chk("gnt_onehot0", d, int'($onehot0(gnt_a[d])), 1);
        if (!clr_seen && cg_a[d] != prev_cg[d])
          chk("gray_step", d, $countones(cg_a[d] ^ prev_cg[d]), 1);
        prev_cg[d] = cg_a[d];
      end
      if (t2_on && gnt_a[0] != 4'h0) t2_log.push_back(tk_a[0]);
    end
  end

  task automatic drive(input logic [3:0] r, input logic e, input logic c);
    @(negedge clk);
    req = r; en = e; clr = c;
  endtask

  // Reset asserted mid-high-phase; outputs must clear without a clock edge.
  task automatic mid_reset(input logic [3:0] r);
    @(posedge clk);
    #2;
    req   = r;
    en    = 1'b1;
    clr   = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_gnt", d, int'(gnt_a[d]), 0);
      chk("rst_ticket", d, int'(tk_a[d]), 0);
      chk("rst_cnt_gray", d, int'(cg_a[d]), 0);
      chk("rst_wrap", d, int'(wrap_a[d]), 0);
      chk("rst_busy", d, int'(busy_a[d]), 0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [3:0] t2_exp [17];

  initial begin
    t2_exp = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
               4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // single requester, full gray sequence through wrap
    @(negedge clk);
    req = 4'b0001; en = 1'b1; t2_on = 1'b1;
    repeat (20) @(negedge clk);
    t2_on = 1'b0;
    chk("t2_count", 0, (t2_log.size() >= 17) ? 1 : 0, 1);
    for (int i = 0; i < 17 && i < t2_log.size(); i++)
      chk("t2_seq", 0, int'(t2_log[i]), int'(t2_exp[i]));

    // mid-clock reset with all requesting, then all-request rotation
    mid_reset(4'b1111);
    repeat (14) drive(4'b1111, 1'b1, 1'b0);

    // sparse requests from a fresh pointer
    mid_reset(4'b1010);
    repeat (9) drive(4'b1010, 1'b1, 1'b0);

    // clear against a live grant condition
    drive(4'b1111, 1'b1, 1'b1);
    repeat (4) drive(4'b1111, 1'b1, 1'b0);

    // enable dropped during a hold window
    drive(4'b1111, 1'b0, 1'b1);
    drive(4'b1111, 1'b1, 1'b0);
    repeat (6) drive(4'b1111, 1'b0, 1'b0);
    repeat (4) drive(4'b0100, 1'b1, 1'b0);

    for (int n = 0; n < 800; n++)
      drive(4'($urandom_range(0, 15)),
            ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 49) == 0));

    drive(4'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
